// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ trigger sequencer: default widths and the
// acquisition FSM state encoding.
package daq_pkg;

  // Width of the trigger divider's pulse counter; the frame tag copies it verbatim.
  localparam int DIV_PULSE_CTR_W = 6;

  localparam int DEF_DLY_W  = 8;
  localparam int DEF_LEN_W  = 10;
  localparam int DEF_TAG_W  = DIV_PULSE_CTR_W;
  localparam int DEF_MISS_W = 8;

  // Acquisition FSM states; the encoding is visible on the state debug port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_ACQ   = 2'd2,
    ST_FRAME = 2'd3
  } daq_state_t;

endpackage

// File: rtl/daq_trig_sequencer_sat_counter.sv
// Saturating up-counter. It holds at all-ones and clears synchronously on clr
// or asynchronously on rst.
module sat_counter
  import daq_pkg::*;
#(
  parameter int W = DEF_MISS_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // Count up on inc and stop at the maximum value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/daq_trig_sequencer.sv
// DAQ trigger sequencer. It runs one acquisition per accepted trigger:
// a programmable delay, then a capture window of acq_len samples, then a frame
// handshake with the readout stage.
//
// Handshakes:
//  - Trigger: a trigger is accepted at a clock edge where trig_out=1 and
//    trig_rdy=1. trig_rdy is high only in IDLE, so any trig_out seen while it
//    is low counts as a miss.
//  - Frame: the frame transfers at a clock edge where frame_valid=1 and
//    frame_ack=1. frame_valid stays high with stable tag, fb and len until that
//    edge. frame_ack has no effect while frame_valid is low.
module daq_trig_sequencer
  import daq_pkg::*;
#(
  parameter int DLY_W  = DEF_DLY_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int MISS_W = DEF_MISS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig_out,
  input  logic              trig_strb,
  input  logic [TAG_W-1:0]  pulse_ctr,
  input  logic [DLY_W-1:0]  acq_delay,
  input  logic [LEN_W-1:0]  acq_len,
  input  logic              frame_ack,
  output logic              acq_en,
  output logic [LEN_W-1:0]  acq_addr,
  output logic              frame_valid,
  output logic [TAG_W-1:0]  frame_tag,
  output logic              frame_fb,
  output logic [LEN_W-1:0]  frame_len,
  output logic              trig_rdy,
  output logic [MISS_W-1:0] missed_ctr,
  output logic [1:0]        state_dbg
);

  daq_state_t       state;
  logic [DLY_W-1:0] dly_cnt;
  logic             accept;
  logic             miss;

  // After reset, trig_rdy is low for one cycle while the FSM is already in
  // IDLE. A trigger in that cycle is treated as a miss, so the divider always
  // sees a rising edge of trig_rdy before it can fire again.
  assign accept    = (state == ST_IDLE) && trig_rdy && trig_out;
  assign miss      = trig_out && !accept;
  assign state_dbg = state;

  // Acquisition FSM. frame_len also serves as the latched sample count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      dly_cnt     <= '0;
      trig_rdy    <= 1'b0;
      acq_en      <= 1'b0;
      acq_addr    <= '0;
      frame_valid <= 1'b0;
      frame_tag   <= '0;
      frame_fb    <= 1'b0;
      frame_len   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          trig_rdy <= 1'b1;
          if (accept) begin
            trig_rdy  <= 1'b0;
            frame_tag <= pulse_ctr;
            frame_fb  <= trig_strb;
            frame_len <= acq_len;
            dly_cnt   <= acq_delay;
            if (acq_delay != '0) begin
              state <= ST_DELAY;
            end else if (acq_len != '0) begin
              state    <= ST_ACQ;
              acq_en   <= 1'b1;
              acq_addr <= '0;
            end else begin
              state       <= ST_FRAME;
              frame_valid <= 1'b1;
            end
          end
        end
        ST_DELAY: begin
          if (dly_cnt == DLY_W'(1)) begin
            if (frame_len != '0) begin
              state    <= ST_ACQ;
              acq_en   <= 1'b1;
              acq_addr <= '0;
            end else begin
              state       <= ST_FRAME;
              frame_valid <= 1'b1;
            end
          end else begin
            dly_cnt <= dly_cnt - DLY_W'(1);
          end
        end
        ST_ACQ: begin
          if (acq_addr == (frame_len - LEN_W'(1))) begin
            state       <= ST_FRAME;
            acq_en      <= 1'b0;
            acq_addr    <= '0;
            frame_valid <= 1'b1;
          end else begin
            acq_addr <= acq_addr + LEN_W'(1);
          end
        end
        ST_FRAME: begin
          if (frame_ack) begin
            state       <= ST_IDLE;
            frame_valid <= 1'b0;
            trig_rdy    <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Diagnostic count of triggers dropped while busy.
  sat_counter #(.W(MISS_W)) u_missed (
    .clk (clk),
    .rst (rst),
    .inc (miss),
    .clr (1'b0),
    .cnt (missed_ctr)
  );

endmodule

// File: tb/tb_daq_trig_sequencer.sv
// Bench for daq_trig_sequencer. Two instances share the same stimulus: the
// main one uses an 8-bit miss counter and the second uses a 2-bit miss counter
// to exercise saturation.
`timescale 1ns/1ps
module tb_daq_trig_sequencer;
  import daq_pkg::*;

  localparam int DLY_W   = 8;
  localparam int LEN_W   = 10;
  localparam int TAG_W   = 6;
  localparam int MISS_W  = 8;
  localparam int MISS2_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic             trig_out  = 1'b0;
  logic             trig_strb = 1'b0;
  logic [TAG_W-1:0] pulse_ctr = '0;
  logic [DLY_W-1:0] acq_delay = '0;
  logic [LEN_W-1:0] acq_len   = '0;
  logic             frame_ack = 1'b0;

  logic              acq_en, frame_valid, frame_fb, trig_rdy;
  logic [LEN_W-1:0]  acq_addr, frame_len;
  logic [TAG_W-1:0]  frame_tag;
  logic [MISS_W-1:0] missed_ctr;
  logic [1:0]        state_dbg;

  logic               acq_en2, frame_valid2, frame_fb2, trig_rdy2;
  logic [LEN_W-1:0]   acq_addr2, frame_len2;
  logic [TAG_W-1:0]   frame_tag2;
  logic [MISS2_W-1:0] missed_ctr2;
  logic [1:0]         state_dbg2;

  daq_trig_sequencer #(.DLY_W(DLY_W), .LEN_W(LEN_W), .TAG_W(TAG_W), .MISS_W(MISS_W)) dut (
    .clk(clk), .rst(rst), .trig_out(trig_out), .trig_strb(trig_strb), .pulse_ctr(pulse_ctr),
    .acq_delay(acq_delay), .acq_len(acq_len), .frame_ack(frame_ack), .acq_en(acq_en),
    .acq_addr(acq_addr), .frame_valid(frame_valid), .frame_tag(frame_tag), .frame_fb(frame_fb),
    .frame_len(frame_len), .trig_rdy(trig_rdy), .missed_ctr(missed_ctr), .state_dbg(state_dbg)
  );

  daq_trig_sequencer #(.DLY_W(DLY_W), .LEN_W(LEN_W), .TAG_W(TAG_W), .MISS_W(MISS2_W)) dut2 (
    .clk(clk), .rst(rst), .trig_out(trig_out), .trig_strb(trig_strb), .pulse_ctr(pulse_ctr),
    .acq_delay(acq_delay), .acq_len(acq_len), .frame_ack(frame_ack), .acq_en(acq_en2),
    .acq_addr(acq_addr2), .frame_valid(frame_valid2), .frame_tag(frame_tag2), .frame_fb(frame_fb2),
    .frame_len(frame_len2), .trig_rdy(trig_rdy2), .missed_ctr(missed_ctr2), .state_dbg(state_dbg2)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  // Each expected sample is packed as {cycle, addr}.
  logic [31+LEN_W:0] exp_q[$];
  typedef struct packed {
    int               cyc;
    logic [TAG_W-1:0] tag;
    logic             fb;
    logic [LEN_W-1:0] len;
  } frame_t;
  frame_t frm_q[$];
  int     fall_q[$];
  int     rdy_q[$];

  // Reference model: count of dropped triggers and the last accepted frame fields.
  int               miss     = 0;
  logic [TAG_W-1:0] last_tag = '0;
  logic             last_fb  = 1'b0;
  logic [LEN_W-1:0] last_len = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic              prev_fv  = 1'b0;
  logic              prev_rdy = 1'b0;
  logic [31+LEN_W:0] e_s;
  frame_t            cur;
  int                t_s;

  always @(negedge clk) begin
    if (rst) begin
      prev_fv  = 1'b0;
      prev_rdy = 1'b0;
    end else begin
      if (acq_en) begin
        if (exp_q.size() == 0) begin
          chk("acq_en_unexpected", 1, 0);
        end else begin
          e_s = exp_q.pop_front();
          chk("acq_addr", acq_addr, e_s[LEN_W-1:0]);
          chk("acq_cycle", cyc, e_s[31+LEN_W:LEN_W]);
        end
      end else begin
        chk("addr_zero_when_idle", acq_addr, 0);
      end
      if (frame_valid && !prev_fv) begin
        if (frm_q.size() == 0) begin
          chk("frame_unexpected", 1, 0);
        end else begin
          cur = frm_q.pop_front();
          chk("frame_cycle", cyc, cur.cyc);
          chk("frame_tag", frame_tag, cur.tag);
          chk("frame_fb", frame_fb, cur.fb);
          chk("frame_len", frame_len, cur.len);
        end
      end else if (frame_valid) begin
        chk("frame_tag_stable", frame_tag, cur.tag);
        chk("frame_len_stable", frame_len, cur.len);
      end
      if (!frame_valid && prev_fv) begin
        if (fall_q.size() == 0) chk("frame_fall_unexpected", 1, 0);
        else begin
          t_s = fall_q.pop_front();
          chk("frame_fall_cycle", cyc, t_s);
        end
      end
      if (trig_rdy && !prev_rdy) begin
        if (rdy_q.size() == 0) chk("rdy_rise_unexpected", 1, 0);
        else begin
          t_s = rdy_q.pop_front();
          chk("rdy_rise_cycle", cyc, t_s);
        end
      end
      prev_fv  = frame_valid;
      prev_rdy = trig_rdy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic idle_check();
    chk("idle_rdy", trig_rdy, 1);
    chk("idle_fv", frame_valid, 0);
    chk("idle_en", acq_en, 0);
    chk("idle_state", state_dbg, 0);
    chk("idle_tag", frame_tag, last_tag);
    chk("idle_fb", frame_fb, last_fb);
    chk("idle_len", frame_len, last_len);
    chk("missed", missed_ctr, sat(miss, MISS_W));
    chk("idle_rdy2", trig_rdy2, 1);
    chk("idle_fv2", frame_valid2, 0);
    chk("idle_en2", acq_en2, 0);
    chk("idle_addr2", acq_addr2, 0);
    chk("idle_state2", state_dbg2, 0);
    chk("idle_tag2", frame_tag2, last_tag);
    chk("idle_fb2", frame_fb2, last_fb);
    chk("idle_len2", frame_len2, last_len);
    chk("missed2", missed_ctr2, sat(miss, MISS2_W));
  endtask

  // Called at posedge+1 while the DUT is ready. The trigger is held during
  // cycle n. Samples are expected at n+1+d+i, the frame at f=n+1+d+len, and
  // the ack at a=f+ack_gap, after which frame_valid falls and trig_rdy rises
  // at a+1. Every trig_out during cycles n+1..a is a miss.
  task automatic run_txn(input int d, input int len, input int tag, input bit strb,
                         input int busy_pct, input bit acq3, input bit miss_on_ack,
                         input int ack_gap);
    int n, f, a, acq0;
    acq_delay = DLY_W'(d);
    acq_len   = LEN_W'(len);
    pulse_ctr = TAG_W'(tag);
    trig_strb = strb;
    trig_out  = 1'b1;
    n    = cyc;
    acq0 = n + 1 + d;
    f    = acq0 + len;
    a    = f + ack_gap;
    for (int i = 0; i < len; i++) exp_q.push_back({32'(acq0 + i), LEN_W'(i)});
    frm_q.push_back('{f, TAG_W'(tag), strb, LEN_W'(len)});
    fall_q.push_back(a + 1);
    rdy_q.push_back(a + 1);
    last_tag = TAG_W'(tag);
    last_fb  = strb;
    last_len = LEN_W'(len);
    step();
    chk("rdy_low_after_accept", trig_rdy, 0);
    while (cyc <= a) begin
      bit t;
      t = ($urandom_range(0, 99) < busy_pct);
      if (acq3 && cyc >= acq0 && cyc < acq0 + 3) t = 1'b1;
      if (miss_on_ack && cyc == a) t = 1'b1;
      trig_out  = t;
      trig_strb = t & 1'($urandom_range(0, 1));
      pulse_ctr = TAG_W'($urandom);
      acq_delay = DLY_W'($urandom);
      acq_len   = LEN_W'($urandom);
      frame_ack = (cyc == a) || (cyc < f && $urandom_range(0, 7) == 0);
      if (t) miss++;
      step();
    end
    trig_out  = 1'b0;
    trig_strb = 1'b0;
    frame_ack = 1'b0;
    idle_check();
  endtask

  task automatic release_reset();
    rst = 1'b0;
    rdy_q.push_back(cyc + 1);
    chk("rdy_low_at_release", trig_rdy, 0);
    step();
    chk("rdy_high_after_release", trig_rdy, 1);
    chk("rel_en", acq_en, 0);
    chk("rel_addr", acq_addr, 0);
    chk("rel_fv", frame_valid, 0);
    chk("rel_tag", frame_tag, 0);
    chk("rel_fb", frame_fb, 0);
    chk("rel_len", frame_len, 0);
    chk("rel_missed", missed_ctr, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    repeat (3) step();
    chk("rst_rdy", trig_rdy, 0);
    chk("rst_en", acq_en, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_missed", missed_ctr, 0);
    chk("rst_state", state_dbg, 0);
    release_reset();

    // Directed: delay 3, len 4, tag 5, fb 1, ack two cycles into FRAME.
    run_txn(3, 4, 5, 1'b1, 0, 1'b0, 1'b0, 2);
    // Directed: zero delay and zero length go straight to FRAME.
    run_txn(0, 0, 33, 1'b0, 0, 1'b0, 1'b0, 3);
    // Directed: three triggers during ACQ plus one coincident with the ack.
    run_txn(2, 5, 9, 1'b0, 0, 1'b1, 1'b1, 1);
    chk("missed_is_4", missed_ctr, 4);
    chk("missed2_sat_3", missed_ctr2, 3);
    // A fifth busy trigger: the wide counter keeps counting, the narrow one holds.
    run_txn(1, 2, 17, 1'b1, 0, 1'b0, 1'b1, 0);
    chk("missed_is_5", missed_ctr, 5);
    chk("missed2_hold_3", missed_ctr2, 3);
    // Boundary cases: maximum delay and maximum length.
    run_txn(255, 1, 63, 1'b1, 0, 1'b0, 1'b0, 0);
    run_txn(0, 1023, 42, 1'b0, 0, 1'b0, 1'b0, 1);

    // Randomized transactions with idle gaps that carry stray acks.
    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 3)) begin
        frame_ack = 1'($urandom_range(0, 1));
        step();
      end
      frame_ack = 1'b0;
      run_txn($urandom_range(0, 6), $urandom_range(0, 8), $urandom_range(0, 63),
              1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? 15 : 0,
              1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end

    // Reset while the capture address is 2.
    acq_delay = 8'd2;
    acq_len   = 10'd6;
    pulse_ctr = 6'd7;
    trig_strb = 1'b1;
    trig_out  = 1'b1;
    n = cyc;
    for (int i = 0; i < 6; i++) exp_q.push_back({32'(n + 3 + i), LEN_W'(i)});
    step();
    trig_out  = 1'b0;
    trig_strb = 1'b0;
    while (cyc < n + 5) step();
    chk("addr_before_rst", acq_addr, 2);
    #1 rst = 1'b1;
    #1;
    chk("async_en_drop", acq_en, 0);
    chk("async_fv_drop", frame_valid, 0);
    chk("async_rdy_drop", trig_rdy, 0);
    chk("async_missed_clr", missed_ctr, 0);
    chk("async_missed2_clr", missed_ctr2, 0);
    exp_q.delete();
    frm_q.delete();
    fall_q.delete();
    rdy_q.delete();
    miss     = 0;
    last_tag = '0;
    last_fb  = 1'b0;
    last_len = '0;
    repeat (2) step();
    release_reset();
    run_txn(1, 6, 11, 1'b0, 0, 1'b0, 1'b0, 2);

    repeat (3) step();
    chk("exp_q_drained", exp_q.size(), 0);
    chk("frm_q_drained", frm_q.size(), 0);
    chk("fall_q_drained", fall_q.size(), 0);
    chk("rdy_q_drained", rdy_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/daq_trig_sequencer.md
Name: daq_trig_sequencer

Overview:
- Downstream consumer of the trigger divider's trig_out/trig_strb/pulse_ctr.
- Runs one acquisition per accepted trigger: programmable delay, then a sample-capture window of programmable length, then a frame handshake to the readout/UART stage.
- Drives trig_rdy back to the divider. Every rising edge of trig_rdy re-arms the divider.

Parameters:
- DLY_W, 8, width of acq_delay and of the delay counter.
- LEN_W, 10, width of acq_len and acq_addr.
- TAG_W, 6, width of the pulse tag; must equal pulse_ctr width.
- MISS_W, 8, width of the saturating missed-trigger counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- trig_out  in  1  single-cycle trigger from the divider.
- trig_strb  in  1  single-cycle strobe, coincident with trig_out when the pulse is real FB/FF data.
- pulse_ctr  in  TAG_W  divider pulse count, valid with trig_out.
- acq_delay  in  DLY_W  cycles from acceptance to first sample; quasi-static.
- acq_len  in  LEN_W  samples per acquisition; quasi-static.
- frame_ack  in  1  readout has consumed the frame.
- acq_en  out  1  sample-write enable to the capture RAM.
- acq_addr  out  LEN_W  capture RAM address.
- frame_valid  out  1  frame ready for readout.
- frame_tag  out  TAG_W  pulse_ctr latched at acceptance.
- frame_fb  out  1  trig_strb latched at acceptance.
- frame_len  out  LEN_W  acq_len latched at acceptance.
- trig_rdy  out  1  high only in IDLE.
- missed_ctr  out  MISS_W  triggers seen while busy; saturating.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs go to 0, including trig_rdy.
  - trig_rdy goes high on the first clk edge after rst deasserts, so the divider sees a rising edge.
- States: IDLE, DELAY, ACQ, FRAME.
- IDLE:
  - trig_rdy=1.
  - On trig_out=1 at edge N, latch pulse_ctr, trig_strb, acq_delay and acq_len.
  - trig_rdy=0 from N+1.
  - Next state: DELAY if acq_delay!=0; else ACQ if acq_len!=0; else FRAME.
- DELAY:
  - Down-counter loaded with latched delay.
  - Leaves after exactly acq_delay cycles in DELAY.
  - Next state: ACQ, or FRAME if latched len=0.
- ACQ:
  - acq_en=1 for exactly latched-len consecutive cycles.
  - acq_addr runs 0..len-1, incrementing by 1 per cycle.
  - acq_en goes low and acq_addr returns to 0 the cycle after the last sample.
  - Next state: FRAME.
- Latency: first acq_en cycle is N+1+acq_delay.
- FRAME:
  - frame_valid=1 with frame_tag/frame_fb/frame_len stable.
  - frame_ack is honoured only while frame_valid=1. Ack is accepted at the edge where both are high.
  - frame_valid=0 and state=IDLE next cycle; trig_rdy=1 that cycle.
  - frame_ack outside FRAME is ignored.
- Busy triggers: trig_out while not IDLE is dropped and missed_ctr increments, saturating at all-ones.
  - The divider normally blocks these; the counter exists for diagnostics.
- Simultaneous ack and trigger in FRAME: the trigger is a miss. trig_rdy rises the next cycle.
- acq_delay/acq_len changes mid-operation have no effect until the next acceptance.
- Reset mid-operation: abort immediately. acq_en and frame_valid drop asynchronously. missed_ctr clears.
- acq_addr never exceeds len-1. len = 2^LEN_W-1 is the maximum.

Decomposition:
- Shared package daq_pkg holds:
  - state encoding localparams (IDLE=0, DELAY=1, ACQ=2, FRAME=3);
  - default DLY_W/LEN_W/TAG_W;
  - TAG_W tied to the divider's pulse counter width.
- One natural sub-module: sat_counter (parameterised width, inc, clr, saturates at max), used for missed_ctr.
- The delay and address counters stay inline in the FSM.

Test Plan:
- Reset release, no triggers -> trig_rdy 0 during rst, 1 one cycle after release. All other outputs 0.
- delay=3, len=4, trigger at N with pulse_ctr=5, strb=1:
  - trig_rdy=0 at N+1;
  - acq_en high at N+4..N+7 with addr 0,1,2,3;
  - frame_valid at N+8 with tag=5, fb=1, len=4;
  - ack at N+10 -> frame_valid=0 and trig_rdy=1 at N+11.
- delay=0, len=0 -> FRAME the cycle after the trigger, no acq_en pulses. Ack returns to IDLE.
- 3 triggers during ACQ, and one coincident with frame_ack -> missed_ctr=4, no second acquisition.
- MISS_W=2, 5 busy triggers -> missed_ctr holds at 3.
- rst asserted mid-ACQ at addr=2 -> acq_en=0 immediately. After release, trig_rdy=1 next cycle and a new trigger runs a full window from addr 0.
